// File: rtl/pipe_depth_ctrl_pkg.sv
// Shared types and constants for the pipeline depth controller.
// Voted state encoding, depth/timer widths and the depth range check.
package pipe_depth_ctrl_pkg;

  typedef logic [8:0]  depth_t;
  typedef logic [10:0] timer_t;
  typedef logic [7:0]  cnt_t;

  typedef enum logic [2:0] {
    S_WAIT_RUN  = 3'd0,
    S_READY     = 3'd1,
    S_LOAD      = 3'd2,
    S_RESTART   = 3'd3,
    S_WAIT_DROP = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam depth_t DEPTH_DEFAULT   = 9'd80;
  localparam depth_t DEPTH_MIN       = 9'd4;
  localparam depth_t DEPTH_MAX       = 9'd500;
  localparam timer_t RESTART_TIMEOUT = 11'd1023;

  function automatic logic depth_ok(input depth_t d, input depth_t lo, input depth_t hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/pipe_depth_ctrl_if.sv
// Configuration handshake plus pipe start sequencer link.
// master = requester/sequencer side, slave = the controller.
interface pipe_depth_ctrl_if;
  import pipe_depth_ctrl_pkg::*;

  logic   CFG_REQ;
  depth_t CFG_DEPTH;
  logic   CFG_ACK;
  logic   CFG_NAK;
  depth_t PDEPTH;
  logic   RESTART;
  logic   PIPE_RE;
  logic   READY;
  logic   ERR;
  cnt_t   RESTART_CNT;

  modport master (
    output CFG_REQ, CFG_DEPTH, PIPE_RE,
    input  CFG_ACK, CFG_NAK, PDEPTH, RESTART, READY, ERR, RESTART_CNT
  );

  modport slave (
    input  CFG_REQ, CFG_DEPTH, PIPE_RE,
    output CFG_ACK, CFG_NAK, PDEPTH, RESTART, READY, ERR, RESTART_CNT
  );

endinterface

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/pipe_depth_ctrl.sv
// Pipeline depth controller: accepts depth changes, restarts the pipe and
// watches the restart for timeout. All state is triplicated and voted.
module pipe_depth_ctrl
  import pipe_depth_ctrl_pkg::*;
#(
  parameter depth_t DEFAULT_DEPTH = DEPTH_DEFAULT,
  parameter depth_t MIN_DEPTH     = DEPTH_MIN,
  parameter depth_t MAX_DEPTH     = DEPTH_MAX,
  parameter timer_t TIMEOUT       = RESTART_TIMEOUT
) (
  input logic              CLK,
  input logic              RST,
  pipe_depth_ctrl_if.slave bus
);

  // Three copies of each register; _v is the voted value all logic reads.
  logic [2:0][2:0] state_q;
  depth_t [2:0]    pdepth_q;
  timer_t [2:0]    timer_q;
  cnt_t [2:0]      cnt_q;
  logic [2:0]      err_q;
  logic [2:0]      via_q;
  logic [2:0]      nak_q;

  logic [2:0] state_raw;
  state_t     state_v, state_d;
  depth_t     pdepth_v, pdepth_d;
  timer_t     timer_v, timer_d;
  cnt_t       cnt_v, cnt_d;
  logic       err_v, err_d;
  logic       via_v, via_d;
  logic       nak_v, nak_d;
  logic       serve;

  tmr_vote #(.W(3))  u_vote_state  (.a(state_q[0]),  .b(state_q[1]),  .c(state_q[2]),  .y(state_raw));
  tmr_vote #(.W(9))  u_vote_pdepth (.a(pdepth_q[0]), .b(pdepth_q[1]), .c(pdepth_q[2]), .y(pdepth_v));
  tmr_vote #(.W(11)) u_vote_timer  (.a(timer_q[0]),  .b(timer_q[1]),  .c(timer_q[2]),  .y(timer_v));
  tmr_vote #(.W(8))  u_vote_cnt    (.a(cnt_q[0]),    .b(cnt_q[1]),    .c(cnt_q[2]),    .y(cnt_v));
  tmr_vote #(.W(1))  u_vote_err    (.a(err_q[0]),    .b(err_q[1]),    .c(err_q[2]),    .y(err_v));
  tmr_vote #(.W(1))  u_vote_via    (.a(via_q[0]),    .b(via_q[1]),    .c(via_q[2]),    .y(via_v));
  tmr_vote #(.W(1))  u_vote_nak    (.a(nak_q[0]),    .b(nak_q[1]),    .c(nak_q[2]),    .y(nak_v));

  assign state_v = state_t'(state_raw);

  // A request that was just rejected is ignored for one cycle so a
  // requester reacting on the next edge cannot collect a second NAK.
  assign serve = bus.CFG_REQ && !nak_v;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_v;
    pdepth_d = pdepth_v;
    timer_d  = timer_v;
    cnt_d    = cnt_v;
    err_d    = err_v;
    via_d    = via_v;
    nak_d    = 1'b0;
    unique case (state_v)
      S_WAIT_DROP: begin
        timer_d = timer_v + 11'd1;
        if (!bus.PIPE_RE) begin
          state_d = S_WAIT_RUN;
        end else if (timer_v == TIMEOUT) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_WAIT_RUN: begin
        timer_d = timer_v + 11'd1;
        if (bus.PIPE_RE) begin
          state_d = S_READY;
          // Only a run reached through a restart counts; the post-reset one does not.
          if (via_v) begin
            via_d = 1'b0;
            if (cnt_v != 8'hFF) cnt_d = cnt_v + 8'd1;
          end
        end else if (timer_v == TIMEOUT) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_READY, S_FAULT: begin
        if (state_v == S_FAULT) err_d = 1'b1;
        if (serve) begin
          if (depth_ok(bus.CFG_DEPTH, MIN_DEPTH, MAX_DEPTH)) state_d = S_LOAD;
          else                                               nak_d   = 1'b1;
        end
      end
      S_LOAD: begin
        pdepth_d = bus.CFG_DEPTH;
        via_d    = 1'b1;
        state_d  = S_RESTART;
      end
      S_RESTART: begin
        timer_d = '0;
        state_d = S_WAIT_DROP;
      end
      default: state_d = S_WAIT_RUN;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every copy samples the same voted values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= {3{S_WAIT_RUN}};
      pdepth_q <= {3{DEFAULT_DEPTH}};
      timer_q  <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      via_q    <= '0;
      nak_q    <= '0;
    end else begin
      state_q  <= {3{state_d}};
      pdepth_q <= {3{pdepth_d}};
      timer_q  <= {3{timer_d}};
      cnt_q    <= {3{cnt_d}};
      err_q    <= {3{err_d}};
      via_q    <= {3{via_d}};
      nak_q    <= {3{nak_d}};
    end
  end

  assign bus.READY       = (state_v == S_READY);
  assign bus.RESTART     = (state_v == S_RESTART);
  assign bus.CFG_ACK     = (state_v == S_LOAD);
  assign bus.CFG_NAK     = nak_v;
  assign bus.PDEPTH      = pdepth_v;
  assign bus.ERR         = err_v;
  assign bus.RESTART_CNT = cnt_v;

endmodule
